program_encoder: RTL and testbench

PROGRAM_ENCODER -- requirements
Module: program_encoder

---
 rtl/program_encoder.sv | 129 ++++++++++++
 tb/tb_program_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_encoder.sv
// Packs decoded instruction field records into 16-bit words and writes them to program memory.
// Optional define PROGRAM_ENCODER_OPCODE_CHECK_EN rejects opcodes 1010-1110 into ERROR without writing.
module program_encoder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic [3:0]           in_rd,
  input  logic [3:0]           in_rs,
  input  logic [3:0]           in_rt,
  input  logic [2:0]           in_nzp,
  input  logic [7:0]           in_immediate,
  output logic                 mem_write_valid,
  input  logic                 mem_write_ready,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_BITS:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [3:0] OP_RET = 4'b1111;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [3:0]           op_q, op_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic [DATA_BITS-1:0] enc;

  // Unused field positions are forced to zero so stray input bits never leak into the word.
  always_comb begin
    enc = '0;
    unique case (in_opcode)
      4'b0000, 4'b1111: enc = {in_opcode, 12'h000};
      4'b0001:          enc = {in_opcode, in_nzp, 1'b0, in_immediate};
      4'b0010, 4'b1000: enc = {in_opcode, 4'h0, in_rs, in_rt};
      4'b0111:          enc = {in_opcode, in_rd, in_rs, 4'h0};
      4'b1001:          enc = {in_opcode, in_rd, in_immediate};
      default:          enc = {in_opcode, in_rd, in_rs, in_rt};
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_d    = op_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d = S_ACCEPT;
          addr_d  = base_addr;
          count_d = '0;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
`ifdef PROGRAM_ENCODER_OPCODE_CHECK_EN
          if (in_opcode inside {[4'b1010:4'b1110]}) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_WRITE;
            data_d  = enc;
            op_d    = in_opcode;
          end
`else
          state_d = S_WRITE;
          data_d  = enc;
          op_d    = in_opcode;
`endif
        end
      end
      S_WRITE: begin
        if (mem_write_ready) begin
          addr_d  = addr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
          count_d = count_q + {{ADDR_BITS{1'b0}}, 1'b1};
          if (op_q == OP_RET)    state_d = S_DONE;
          else if (addr_q == '1) state_d = S_ERROR;
          else                   state_d = S_ACCEPT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

  assign in_ready          = (state_q == S_ACCEPT);
  assign mem_write_valid   = (state_q == S_WRITE);
  assign mem_write_address = addr_q;
  assign mem_write_data    = data_q;
  assign busy              = (state_q == S_ACCEPT) || (state_q == S_WRITE);
  assign done              = (state_q == S_DONE);
  assign error             = (state_q == S_ERROR);
  assign word_count        = count_q;

endmodule

// File: tb/tb_program_encoder.sv
// Scoreboard bench: stimulus pushes expected memory writes, a negedge monitor checks each write handshake.
module tb_program_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode, in_rd, in_rs, in_rt;
  logic [2:0]  in_nzp;
  logic [7:0]  in_immediate;
  logic        mem_write_valid;
  logic        mem_write_ready;
  logic [7:0]  mem_write_address;
  logic [15:0] mem_write_data;
  logic        busy, done, error;
  logic [8:0]  word_count;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] exp_addr;
  int         total = 0;
  int         bad   = 0;

  program_encoder #(.ADDR_BITS(8), .DATA_BITS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_nzp(in_nzp), .in_immediate(in_immediate),
    .mem_write_valid(mem_write_valid), .mem_write_ready(mem_write_ready),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset && mem_write_valid && mem_write_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual=%h@%h required=none", mem_write_data, mem_write_address);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_write_address !== e.a || mem_write_data !== e.d) begin
          bad++;
          $display("FAIL write actual=%h@%h required=%h@%h",
                   mem_write_data, mem_write_address, e.d, e.a);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [2:0] nzp, input logic [7:0] imm,
                      input logic [15:0] exp_d, input bit push);
    bit ok;
    if (push) begin
      exp_q.push_back('{a: exp_addr, d: exp_d});
      exp_addr = exp_addr + 8'd1;
    end
    in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt; in_nzp = nzp; in_immediate = imm;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=no_in_ready required=in_ready op=%h", op);
    end
  endtask

  task automatic wait_done(input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) cnt++;
      tick();
    end
    chk(name, cnt, 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_nzp = '0; in_immediate = '0;
    mem_write_ready = 1'b1;
    exp_addr = '0;
    #3;
    chk("rst_outputs", {in_ready, mem_write_valid, busy, done, error}, 0);
    chk("rst_addr_data", {mem_write_address, mem_write_data}, 0);
    chk("rst_count", word_count, 0);
    tick();
    reset = 1'b1;
    tick();

    // ADD + RET from 0x10; a start while accepting must be ignored
    pulse_start(8'h10);
    exp_addr = 8'h10;
    chk("busy_accept", {busy, in_ready}, 2'b11);
    pulse_start(8'h55);
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00, 16'h3123, 1);
    send(4'hF, 4'hF, 4'hF, 4'hF, 3'h7, 8'hFF, 16'hF000, 1);
    wait_done("done_pulse_s1");
    chk("count_s1", word_count, 2);
    chk("idle_s1", {busy, error, in_ready}, 0);

    // stall: word held stable, no record accepted until back in ACCEPT
    mem_write_ready = 1'b0;
    pulse_start(8'h20);
    exp_addr = 8'h20;
    send(4'h9, 4'h4, 4'hF, 4'hF, 3'h7, 8'h7F, 16'h947F, 1);
    in_opcode = 4'hF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {mem_write_valid, in_ready, mem_write_address, mem_write_data},
          {1'b1, 1'b0, 8'h20, 16'h947F});
      tick();
    end
    exp_q.push_back('{a: 8'h21, d: 16'hF000});
    mem_write_ready = 1'b1;
    tick();
    chk("no_same_cycle_accept", {in_ready, mem_write_valid}, 2'b10);
    tick();
    in_valid = 1'b0;
    chk("ret_after_stall", {mem_write_valid, mem_write_data}, {1'b1, 16'hF000});
    wait_done("done_pulse_s2");
    chk("count_s2", word_count, 2);

    // address wrap at 0xFF goes to ERROR
    pulse_start(8'hFF);
    exp_addr = 8'hFF;
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00, 16'h3123, 1);
    tick(); tick();
    chk("wrap_error", {error, busy, in_ready, done}, 4'b1000);
    chk("wrap_count", word_count, 1);

    // restart from ERROR, then every encoding with garbage in unused fields
    pulse_start(8'h30);
    exp_addr = 8'h30;
    chk("error_cleared", {error, in_ready}, 2'b01);
    send(4'h1, 4'hF, 4'hF, 4'hF, 3'b101, 8'h2A, 16'h1A2A, 1);
    send(4'h9, 4'h4, 4'hF, 4'hF, 3'h7, 8'h7F, 16'h947F, 1);
    send(4'h2, 4'hF, 4'h4, 4'h5, 3'h7, 8'hFF, 16'h2045, 1);
    send(4'h7, 4'h6, 4'h7, 4'hF, 3'h7, 8'hFF, 16'h7670, 1);
    send(4'h8, 4'hF, 4'h9, 4'hA, 3'h7, 8'hFF, 16'h809A, 1);
    send(4'h0, 4'hF, 4'hF, 4'hF, 3'h7, 8'hFF, 16'h0000, 1);
    send(4'h4, 4'h1, 4'h2, 4'h3, 3'h7, 8'hFF, 16'h4123, 1);
    send(4'h5, 4'hA, 4'hB, 4'hC, 3'h7, 8'hFF, 16'h5ABC, 1);
    send(4'h6, 4'hD, 4'hE, 4'hF, 3'h7, 8'hFF, 16'h6DEF, 1);
    send(4'hF, 4'h1, 4'h2, 4'h3, 3'h7, 8'hFF, 16'hF000, 1);
    wait_done("done_pulse_s3");
    chk("count_s3", word_count, 10);

    // reserved opcode 1100
    pulse_start(8'h40);
    exp_addr = 8'h40;
`ifdef PROGRAM_ENCODER_OPCODE_CHECK_EN
    send(4'hC, 4'h1, 4'h2, 4'h3, 3'h7, 8'hFF, 16'hC123, 0);
    tick(); tick();
    chk("rsvd_error", {error, busy, mem_write_valid}, 3'b100);
    chk("rsvd_count", word_count, 0);
    pulse_start(8'h40);
    send(4'hF, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00, 16'hF000, 1);
    wait_done("done_pulse_s4");
    chk("count_s4", word_count, 1);
`else
    send(4'hC, 4'h1, 4'h2, 4'h3, 3'h7, 8'hFF, 16'hC123, 1);
    send(4'hF, 4'h0, 4'h0, 4'h0, 3'h0, 8'h00, 16'hF000, 1);
    wait_done("done_pulse_s4");
    chk("count_s4", word_count, 2);
`endif

    // reset in the middle of a stalled write abandons the word
    mem_write_ready = 1'b0;
    pulse_start(8'h50);
    exp_addr = 8'h50;
    send(4'h8, 4'h0, 4'h9, 4'hA, 3'h0, 8'h00, 16'h809A, 1);
    void'(exp_q.pop_back());
    chk("pre_reset_write", mem_write_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_flags", {in_ready, mem_write_valid, busy, done, error}, 0);
    chk("async_rst_bus", {mem_write_address, mem_write_data, 7'd0, word_count}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_write_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_idle", {mem_write_valid, busy, in_ready}, 0);
    chk("post_rst_count", word_count, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
